// File: rtl/pwm_pkg.sv
// Shared types for the level-shifted multilevel PWM bank: control FSM states
// and carrier ramp direction.
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        RUN    = 2'd2
    } state_t;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } dir_t;

endpackage

// File: rtl/pwm_band_divider.sv
// Sequential restoring divider: one quotient bit per clock, BIT_WIDTH clocks
// from i_start to a one-cycle o_done pulse; o_quotient holds until the next start.
module pwm_band_divider #(
    parameter int BIT_WIDTH = 16
) (
    input  logic                 MClk,
    input  logic                 RstN,
    input  logic                 i_start,
    input  logic [BIT_WIDTH-1:0] i_dividend,
    input  logic [BIT_WIDTH-1:0] i_divisor,
    output logic                 o_done,
    output logic [BIT_WIDTH-1:0] o_quotient
);

    localparam int CW = $clog2(BIT_WIDTH + 1);

    logic [BIT_WIDTH-1:0] r_rem;
    logic [BIT_WIDTH-1:0] r_quo;
    logic [CW-1:0]        r_cnt;
    logic                 r_busy;
    logic                 r_done;

    logic [BIT_WIDTH:0]   w_trial;
    logic                 w_bit;
    logic [BIT_WIDTH-1:0] w_rem_next;

    // The dividend shifts out of r_quo MSB-first while quotient bits shift in.
    assign w_trial    = {r_rem, r_quo[BIT_WIDTH-1]};
    assign w_bit      = (w_trial >= {1'b0, i_divisor});
    assign w_rem_next = w_bit ? BIT_WIDTH'(w_trial - {1'b0, i_divisor})
                              : w_trial[BIT_WIDTH-1:0];

    // Iteration registers and completion pulse
    always_ff @(posedge MClk or negedge RstN) begin
        if (!RstN) begin
            r_rem  <= '0;
            r_quo  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else if (i_start) begin
            r_rem  <= '0;
            r_quo  <= i_dividend;
            r_cnt  <= CW'(BIT_WIDTH);
            r_busy <= 1'b1;
            r_done <= 1'b0;
        end else if (r_busy) begin
            r_rem  <= w_rem_next;
            r_quo  <= {r_quo[BIT_WIDTH-2:0], w_bit};
            r_cnt  <= r_cnt - CW'(1);
            r_busy <= (r_cnt != CW'(1));
            r_done <= (r_cnt == CW'(1));
        end else begin
            r_done <= 1'b0;
        end
    end

    assign o_done     = r_done;
    assign o_quotient = r_quo;

endmodule

// File: rtl/multilevel_pwm_bank.sv
// Level-shifted multilevel PWM: one shared triangle carrier of band width
// W = PWMMaxCount/LEVELS, offset by k*W per level, with per-level dead time.
module multilevel_pwm_bank
    import pwm_pkg::*;
#(
    parameter int LEVELS    = 4,
    parameter int BIT_WIDTH = 16
) (
    input  logic                  MClk,
    input  logic                  RstN,
    input  logic                  Start,
    input  logic [BIT_WIDTH-1:0]  PWMMaxCount,
    input  logic [BIT_WIDTH-1:0]  StepSize,
    input  logic [BIT_WIDTH-1:0]  DeadTimeCount,
    input  logic [BIT_WIDTH-1:0]  Compare,
    output logic [2*LEVELS-1:0]   S,
    output logic                  Ready,
    output logic                  CfgErr,
    output logic                  PeriodStart
);

    localparam int BW = BIT_WIDTH;

    state_t          r_state;
    dir_t            r_dir;
    logic [BW-1:0]   r_step;
    logic [BW-1:0]   r_dt;
    logic [BW-1:0]   r_w;
    logic [BW-1:0]   r_t;
    logic [BW-1:0]   r_cmp_sh;
    logic            r_ready;
    logic            r_cfg_err;
    logic            r_period_start;

    logic            w_div_start;
    logic            w_div_done;
    logic [BW-1:0]   w_quotient;
    logic            w_run_go;
    logic [BW:0]     w_up_sum;
    logic [BW:0]     w_w_m1;
    logic            w_up_hit;
    logic            w_dn_hit;
    logic [BW-1:0]   w_dn_val;

    assign w_div_start = Start && (r_state != DIVIDE);
    assign w_run_go    = (r_state == RUN) && !Start;

    pwm_band_divider #(
        .BIT_WIDTH (BW)
    ) u_divider (
        .MClk       (MClk),
        .RstN       (RstN),
        .i_start    (w_div_start),
        .i_dividend (PWMMaxCount),
        .i_divisor  (BW'(LEVELS)),
        .o_done     (w_div_done),
        .o_quotient (w_quotient)
    );

    // Carrier turn-around tests are done one bit wider so T+StepSize cannot wrap.
    assign w_up_sum = {1'b0, r_t} + {1'b0, r_step};
    assign w_w_m1   = {1'b0, r_w} - (BW + 1)'(1);
    assign w_up_hit = (w_up_sum >= w_w_m1);
    assign w_dn_hit = (r_t <= r_step);
    assign w_dn_val = r_t - r_step;

    // Control FSM, shared carrier and compare shadow
    always_ff @(posedge MClk or negedge RstN) begin
        if (!RstN) begin
            r_state        <= IDLE;
            r_dir          <= UP;
            r_step         <= '0;
            r_dt           <= '0;
            r_w            <= '0;
            r_t            <= '0;
            r_cmp_sh       <= '0;
            r_ready        <= 1'b0;
            r_cfg_err      <= 1'b0;
            r_period_start <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (Start) begin
                        r_step    <= StepSize;
                        r_dt      <= DeadTimeCount;
                        r_cfg_err <= 1'b0;
                        r_state   <= DIVIDE;
                    end
                end
                DIVIDE: begin
                    if (w_div_done) begin
                        if ((w_quotient == '0) || (r_step == '0)) begin
                            r_cfg_err <= 1'b1;
                            r_state   <= IDLE;
                        end else begin
                            r_state  <= RUN;
                            r_ready  <= 1'b1;
                            r_w      <= w_quotient;
                            r_t      <= '0;
                            r_dir    <= UP;
                            r_cmp_sh <= Compare;
                        end
                    end
                end
                RUN: begin
                    if (Start) begin
                        r_step         <= StepSize;
                        r_dt           <= DeadTimeCount;
                        r_cfg_err      <= 1'b0;
                        r_state        <= DIVIDE;
                        r_ready        <= 1'b0;
                        r_period_start <= 1'b0;
                        r_t            <= '0;
                    end else if (r_w == BW'(1)) begin
                        // Degenerate band: every cycle is a valley.
                        r_t            <= '0;
                        r_period_start <= 1'b1;
                        r_cmp_sh       <= Compare;
                    end else if (r_dir == UP) begin
                        r_period_start <= 1'b0;
                        if (w_up_hit) begin
                            r_t   <= w_w_m1[BW-1:0];
                            r_dir <= DOWN;
                        end else begin
                            r_t <= w_up_sum[BW-1:0];
                        end
                    end else if (w_dn_hit) begin
                        r_t            <= '0;
                        r_dir          <= UP;
                        r_period_start <= 1'b1;
                        r_cmp_sh       <= Compare;
                    end else begin
                        r_t            <= w_dn_val;
                        r_period_start <= 1'b0;
                    end
                end
                default: begin
                    r_state        <= IDLE;
                    r_ready        <= 1'b0;
                    r_period_start <= 1'b0;
                end
            endcase
        end
    end

    assign Ready       = r_ready;
    assign CfgErr      = r_cfg_err;
    assign PeriodStart = r_period_start;

    for (genvar k = 0; k < LEVELS; k++) begin : g_level
        localparam logic [BW:0] K_MULT = (BW + 1)'(k);

        logic [BW:0]   w_pos;
        logic          r_p;
        logic          r_lvl;
        logic [BW-1:0] r_dt_cnt;
        logic [1:0]    r_pair;

        assign w_pos = {1'b0, r_t} + K_MULT * {1'b0, r_w};

        // Level comparator, one cycle behind the carrier
        always_ff @(posedge MClk or negedge RstN) begin
            if (!RstN) begin
                r_p <= 1'b0;
            end else if (w_run_go) begin
                r_p <= ({1'b0, r_cmp_sh} > w_pos);
            end else begin
                r_p <= 1'b0;
            end
        end

        // Dead-time channel: r_pair = {complement, top}, never 2'b11
        always_ff @(posedge MClk or negedge RstN) begin
            if (!RstN) begin
                r_lvl    <= 1'b0;
                r_dt_cnt <= '0;
                r_pair   <= 2'b00;
            end else if (!w_run_go) begin
                r_lvl    <= 1'b0;
                r_dt_cnt <= '0;
                r_pair   <= 2'b00;
            end else if (r_p != r_lvl) begin
                r_lvl <= r_p;
                if (r_dt == '0) begin
                    r_dt_cnt <= '0;
                    r_pair   <= {~r_p, r_p};
                end else begin
                    r_dt_cnt <= r_dt;
                    r_pair   <= 2'b00;
                end
            end else if (r_dt_cnt > BW'(1)) begin
                r_dt_cnt <= r_dt_cnt - BW'(1);
                r_pair   <= 2'b00;
            end else begin
                r_dt_cnt <= '0;
                r_pair   <= {~r_lvl, r_lvl};
            end
        end

        assign S[2*k+1:2*k] = r_pair;
    end

endmodule
